// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input conditioning stage:
// PS/2 scancodes, joystick bit map, coin FSM states and the direction helper.
package arcade_input_pkg;

    // 9-bit codes are {extended, scancode}; direction keys only compare the low byte
    localparam logic [8:0] SC_UP         = 9'h075;
    localparam logic [8:0] SC_DOWN       = 9'h072;
    localparam logic [8:0] SC_LEFT       = 9'h06B;
    localparam logic [8:0] SC_RIGHT      = 9'h074;
    localparam logic [8:0] SC_SPACE      = 9'h029;
    localparam logic [8:0] SC_CTRL       = 9'h014;
    localparam logic [8:0] SC_START1     = 9'h005;
    localparam logic [8:0] SC_START1_ALT = 9'h016;
    localparam logic [8:0] SC_START2     = 9'h006;
    localparam logic [8:0] SC_START2_ALT = 9'h01E;
    localparam logic [8:0] SC_COIN1      = 9'h02E;
    localparam logic [8:0] SC_COIN2      = 9'h036;
    localparam logic [8:0] SC_UP2        = 9'h02D;
    localparam logic [8:0] SC_DOWN2      = 9'h02B;
    localparam logic [8:0] SC_LEFT2      = 9'h023;
    localparam logic [8:0] SC_RIGHT2     = 9'h034;
    localparam logic [8:0] SC_JUMP2      = 9'h01C;
    localparam logic [8:0] SC_TEST       = 9'h02C;

    localparam int JB_RIGHT  = 0;
    localparam int JB_LEFT   = 1;
    localparam int JB_DOWN   = 2;
    localparam int JB_UP     = 3;
    localparam int JB_JUMP   = 4;
    localparam int JB_START1 = 5;
    localparam int JB_START2 = 6;
    localparam int JB_COIN   = 7;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef struct packed {
        dir_t dir;
        logic jump;
        logic start;
    } ctrl_t;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic space;
        logic ctrl;
        logic start1a;
        logic start1b;
        logic start2a;
        logic start2b;
        logic coin1;
        logic coin2;
        logic up2;
        logic down2;
        logic left2;
        logic right2;
        logic jump2;
        logic test;
    } key_latch_t;

    // Rotation first, then SOCD cleaning on the rotated directions.
    function automatic dir_t condition_dirs(dir_t raw, logic rot, logic clean);
        dir_t d;
        d = raw;
        if (rot) begin
            d.up    = raw.left;
            d.down  = raw.right;
            d.left  = raw.down;
            d.right = raw.up;
        end
        if (clean) begin
            if (d.up && d.down) begin
                d.up   = 1'b0;
                d.down = 1'b0;
            end
            if (d.left && d.right) begin
                d.left  = 1'b0;
                d.right = 1'b0;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Fixed-width coin pulse generator: a fresh request edge yields exactly PULSE
// high cycles, followed by a GAP-cycle holdoff in which requests are ignored.
module coin_pulser #(
    parameter int unsigned PULSE = 1,
    parameter int unsigned GAP   = 0
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic req,
    output logic pulse
);

    localparam int unsigned MaxCnt = (PULSE > GAP) ? PULSE : GAP;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] PulseLoad = CntW'(PULSE - 1);
    localparam logic [CntW-1:0] GapLoad   = (GAP == 0) ? '0 : CntW'(GAP - 1);

    arcade_input_pkg::coin_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            req_q;
    logic            rise;

    assign rise = req & ~req_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            arcade_input_pkg::IDLE: begin
                if (rise) begin
                    state_d = arcade_input_pkg::PULSE;
                    cnt_d   = PulseLoad;
                end
            end
            arcade_input_pkg::PULSE: begin
                if (cnt_q == '0) begin
                    if (GAP == 0) begin
                        state_d = arcade_input_pkg::IDLE;
                    end else begin
                        state_d = arcade_input_pkg::GAP;
                        cnt_d   = GapLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            arcade_input_pkg::GAP: begin
                // Edges during holdoff are dropped; req_q keeps tracking so a held
                // request cannot retrigger once the FSM is back in IDLE.
                if (cnt_q == '0) begin
                    state_d = arcade_input_pkg::IDLE;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = arcade_input_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= arcade_input_pkg::IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req;
        end
    end

    assign pulse = (state_q == arcade_input_pkg::PULSE);

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-control conditioning: PS/2 key latches merged with joysticks, screen
// rotation, SOCD cleaning and rate-limited coin pulses for both players.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned COIN_PULSE_CYCLES = 4800000,
    parameter int unsigned COIN_GAP_CYCLES   = 2400000,
    parameter int unsigned CLEAN_SOCD        = 1,
    parameter int unsigned COIN_ON_START     = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic        p1_up,
    output logic        p1_down,
    output logic        p1_left,
    output logic        p1_right,
    output logic        p1_jump,
    output logic        p1_start,
    output logic        p1_coin,
    output logic        p2_up,
    output logic        p2_down,
    output logic        p2_left,
    output logic        p2_right,
    output logic        p2_jump,
    output logic        p2_start,
    output logic        p2_coin,
    output logic        test
);

    logic       prev_tgl_q;
    logic       ps2_event;
    logic       pressed;
    logic [8:0] code;
    key_latch_t keys_q, keys_d;

    assign ps2_event = ps2_key[10] != prev_tgl_q;
    assign pressed   = ps2_key[9];
    assign code      = ps2_key[8:0];

    always_comb begin
        keys_d = keys_q;
        if (ps2_event) begin
            if (code[7:0] == SC_UP[7:0])    keys_d.up    = pressed;
            if (code[7:0] == SC_DOWN[7:0])  keys_d.down  = pressed;
            if (code[7:0] == SC_LEFT[7:0])  keys_d.left  = pressed;
            if (code[7:0] == SC_RIGHT[7:0]) keys_d.right = pressed;
            case (code)
                SC_SPACE:      keys_d.space   = pressed;
                SC_CTRL:       keys_d.ctrl    = pressed;
                SC_START1:     keys_d.start1a = pressed;
                SC_START1_ALT: keys_d.start1b = pressed;
                SC_START2:     keys_d.start2a = pressed;
                SC_START2_ALT: keys_d.start2b = pressed;
                SC_COIN1:      keys_d.coin1   = pressed;
                SC_COIN2:      keys_d.coin2   = pressed;
                SC_UP2:        keys_d.up2     = pressed;
                SC_DOWN2:      keys_d.down2   = pressed;
                SC_LEFT2:      keys_d.left2   = pressed;
                SC_RIGHT2:     keys_d.right2  = pressed;
                SC_JUMP2:      keys_d.jump2   = pressed;
                SC_TEST:       keys_d.test    = pressed;
                default: ;
            endcase
        end
    end

    // prev_tgl follows ps2_key[10] even in reset so no event fires on release.
    always_ff @(posedge clk_sys) begin
        prev_tgl_q <= ps2_key[10];
        if (reset) begin
            keys_q <= '0;
        end else begin
            keys_q <= keys_d;
        end
    end

    dir_t  p1_raw, p2_raw;
    logic  start1, start2;
    logic  coin_req1, coin_req2;
    ctrl_t p1_d, p1_q, p2_d, p2_q;
    logic  test_q;

    always_comb begin
        p1_raw.up    = keys_q.up    | joystick_0[JB_UP];
        p1_raw.down  = keys_q.down  | joystick_0[JB_DOWN];
        p1_raw.left  = keys_q.left  | joystick_0[JB_LEFT];
        p1_raw.right = keys_q.right | joystick_0[JB_RIGHT];
        p2_raw.up    = keys_q.up2    | joystick_1[JB_UP];
        p2_raw.down  = keys_q.down2  | joystick_1[JB_DOWN];
        p2_raw.left  = keys_q.left2  | joystick_1[JB_LEFT];
        p2_raw.right = keys_q.right2 | joystick_1[JB_RIGHT];

        start1 = keys_q.start1a | keys_q.start1b | joystick_0[JB_START1] | joystick_1[JB_START1];
        start2 = keys_q.start2a | keys_q.start2b | joystick_0[JB_START2] | joystick_1[JB_START2];

        p1_d.dir   = condition_dirs(p1_raw, rotate, CLEAN_SOCD != 0);
        p1_d.jump  = keys_q.space | keys_q.ctrl | joystick_0[JB_JUMP];
        p1_d.start = start1;
        p2_d.dir   = condition_dirs(p2_raw, rotate, CLEAN_SOCD != 0);
        p2_d.jump  = keys_q.jump2 | joystick_1[JB_JUMP];
        p2_d.start = start2;

        coin_req1 = keys_q.coin1 | joystick_0[JB_COIN] | ((COIN_ON_START != 0) & start1);
        coin_req2 = keys_q.coin2 | joystick_1[JB_COIN] | ((COIN_ON_START != 0) & start2);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p1_q   <= '0;
            p2_q   <= '0;
            test_q <= 1'b0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            test_q <= keys_q.test;
        end
    end

    assign p1_up    = p1_q.dir.up;
    assign p1_down  = p1_q.dir.down;
    assign p1_left  = p1_q.dir.left;
    assign p1_right = p1_q.dir.right;
    assign p1_jump  = p1_q.jump;
    assign p1_start = p1_q.start;
    assign p2_up    = p2_q.dir.up;
    assign p2_down  = p2_q.dir.down;
    assign p2_left  = p2_q.dir.left;
    assign p2_right = p2_q.dir.right;
    assign p2_jump  = p2_q.jump;
    assign p2_start = p2_q.start;
    assign test     = test_q;

    logic unused_joy;
    assign unused_joy = ^{joystick_0[15:8], joystick_1[15:8]};

    coin_pulser #(
        .PULSE(COIN_PULSE_CYCLES),
        .GAP  (COIN_GAP_CYCLES)
    ) u_coin_p1 (
        .clk_sys(clk_sys),
        .reset  (reset),
        .req    (coin_req1),
        .pulse  (p1_coin)
    );

    coin_pulser #(
        .PULSE(COIN_PULSE_CYCLES),
        .GAP  (COIN_GAP_CYCLES)
    ) u_coin_p2 (
        .clk_sys(clk_sys),
        .reset  (reset),
        .req    (coin_req2),
        .pulse  (p2_coin)
    );

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus queues expected output bits
// tagged with the cycle they must appear in; a negedge monitor pops and compares.
module tb_arcade_input_mapper;

    localparam int unsigned PULSE_C = 8;
    localparam int unsigned GAP_C   = 4;

    localparam int B_P1_UP = 0, B_P1_JUMP = 4, B_P1_START = 5, B_P1_COIN = 6;
    localparam int B_P2_UP = 7, B_P2_START = 12, B_P2_COIN = 13, B_TEST = 14;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0, joystick_1;
    logic        rotate;
    logic p1_up, p1_down, p1_left, p1_right, p1_jump, p1_start, p1_coin;
    logic p2_up, p2_down, p2_left, p2_right, p2_jump, p2_start, p2_coin;
    logic test;

    arcade_input_mapper #(
        .COIN_PULSE_CYCLES(PULSE_C),
        .COIN_GAP_CYCLES  (GAP_C),
        .CLEAN_SOCD       (1),
        .COIN_ON_START    (1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joystick_0(joystick_0),
        .joystick_1(joystick_1),
        .rotate    (rotate),
        .p1_up     (p1_up),
        .p1_down   (p1_down),
        .p1_left   (p1_left),
        .p1_right  (p1_right),
        .p1_jump   (p1_jump),
        .p1_start  (p1_start),
        .p1_coin   (p1_coin),
        .p2_up     (p2_up),
        .p2_down   (p2_down),
        .p2_left   (p2_left),
        .p2_right  (p2_right),
        .p2_jump   (p2_jump),
        .p2_start  (p2_start),
        .p2_coin   (p2_coin),
        .test      (test)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [14:0] mask;
        logic [14:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [14:0] obs;

    assign obs = {test, p2_coin, p2_start, p2_jump, p2_right, p2_left, p2_down, p2_up,
                  p1_coin, p1_start, p1_jump, p1_right, p1_left, p1_down, p1_up};

    task automatic expect_bits(int unsigned at, logic [14:0] mask, logic [14:0] val,
                               string name);
        exp_t e;
        e.at   = at;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic expect_bit(int unsigned at, int idx, logic v, string name);
        logic [14:0] m;
        m      = '0;
        m[idx] = 1'b1;
        expect_bits(at, m, v ? m : 15'h0, name);
    endtask

    task automatic expect_pulse(int unsigned first, int idx, string name);
        expect_bit(first - 1, idx, 1'b0, {name, "_pre"});
        for (int i = 0; i < int'(PULSE_C); i++) expect_bit(first + i, idx, 1'b1, name);
        expect_bit(first + PULSE_C, idx, 1'b0, {name, "_post"});
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(logic pr, logic [8:0] code);
        ps2_key = {~ps2_key[10], pr, code};
    endtask

    always @(negedge clk_sys) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                n_vec++;
                if (exp_q[i].at < cyc || ((obs ^ exp_q[i].val) & exp_q[i].mask) != 15'h0) begin
                    n_err++;
                    $display("FAIL %s @cycle %0d: got %h want %h (mask %h)", exp_q[i].name,
                             exp_q[i].at, obs & exp_q[i].mask, exp_q[i].val, exp_q[i].mask);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    int unsigned t;

    initial begin
        reset      = 1'b1;
        ps2_key    = 11'h775;  // toggle=1 with an up-press code held through reset
        joystick_0 = '0;
        joystick_1 = '0;
        rotate     = 1'b0;
        tick(3);
        expect_bits(cyc, '1, '0, "reset_state");
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) expect_bits(cyc + i, '1, '0, "no_event_after_reset");
        tick(1);
        ps2_key = 11'h775;
        expect_bit(cyc + 2, B_P1_UP, 1'b0, "no_toggle_no_event");
        tick(3);

        key(1'b1, 9'h075);
        expect_bit(cyc + 1, B_P1_UP, 1'b0, "key_up_latency");
        expect_bit(cyc + 2, B_P1_UP, 1'b1, "key_up_press");
        tick(3);
        key(1'b0, 9'h075);
        expect_bit(cyc + 2, B_P1_UP, 1'b0, "key_up_release");
        tick(3);
        key(1'b1, 9'h175);
        expect_bit(cyc + 2, B_P1_UP, 1'b1, "ext_up_press");
        tick(3);
        key(1'b0, 9'h075);
        expect_bit(cyc + 2, B_P1_UP, 1'b0, "ext_up_release");
        tick(3);

        key(1'b1, 9'h029);
        tick(1);
        key(1'b1, 9'h014);
        expect_bit(cyc + 2, B_P1_JUMP, 1'b1, "jump_both");
        tick(2);
        key(1'b0, 9'h029);
        expect_bit(cyc + 2, B_P1_JUMP, 1'b1, "jump_ctrl_holds");
        expect_bit(cyc + 3, B_P1_JUMP, 1'b1, "jump_ctrl_holds2");
        tick(3);
        key(1'b0, 9'h014);
        expect_bit(cyc + 2, B_P1_JUMP, 1'b0, "jump_released");
        tick(3);

        key(1'b1, 9'h02C);
        expect_bit(cyc + 2, B_TEST, 1'b1, "test_press");
        tick(3);
        key(1'b0, 9'h02C);
        expect_bit(cyc + 2, B_TEST, 1'b0, "test_release");
        tick(3);
        key(1'b1, 9'h02D);
        expect_bit(cyc + 2, B_P2_UP, 1'b1, "p2_up_key");
        tick(3);
        key(1'b0, 9'h02D);
        expect_bit(cyc + 2, B_P2_UP, 1'b0, "p2_up_key_release");
        tick(3);

        joystick_0 = 16'h0008;
        rotate     = 1'b1;
        expect_bits(cyc + 1, 15'h000F, 15'h0008, "rotate_up_to_right");
        tick(2);
        rotate = 1'b0;
        expect_bits(cyc + 1, 15'h000F, 15'h0001, "rotate_off_up");
        tick(2);
        joystick_0 = '0;
        tick(2);
        joystick_1 = 16'h0001;
        expect_bits(cyc + 1, 15'h0780, 15'h0400, "p2_joy_right");
        tick(2);
        joystick_1 = 16'h0003;
        expect_bits(cyc + 1, 15'h0780, 15'h0000, "socd_left_right");
        tick(2);
        joystick_1 = '0;
        tick(2);

        // Coin 1: pulse, ignored edge in holdoff, accepted edge once idle.
        t = cyc;
        joystick_0 = 16'h0080;
        expect_pulse(t + 1, B_P1_COIN, "coin1_first");
        expect_bit(t + 1, B_P2_COIN, 1'b0, "coin_players_independent");
        for (int i = 9; i <= 13; i++) expect_bit(t + i, B_P1_COIN, 1'b0, "coin1_holdoff");
        expect_pulse(t + 14, B_P1_COIN, "coin1_after_gap");
        tick(1);
        joystick_0 = '0;
        tick(9);
        joystick_0 = 16'h0080;
        tick(1);
        joystick_0 = '0;
        tick(2);
        joystick_0 = 16'h0080;
        tick(1);
        joystick_0 = '0;
        tick(16);

        // Held coin2 key gives one pulse only.
        t = cyc;
        key(1'b1, 9'h036);
        expect_pulse(t + 2, B_P2_COIN, "coin2_held");
        for (int i = 11; i <= 33; i++) expect_bit(t + i, B_P2_COIN, 1'b0, "coin2_held_once");
        tick(30);
        key(1'b0, 9'h036);
        tick(12);

        // F2 raises start2 and a player-2 coin pulse.
        t = cyc;
        key(1'b1, 9'h006);
        expect_bit(t + 2, B_P2_START, 1'b1, "f2_start2");
        expect_bit(t + 2, B_P1_START, 1'b0, "f2_not_start1");
        expect_bit(t + 2, B_P1_COIN, 1'b0, "f2_not_coin1");
        expect_pulse(t + 2, B_P2_COIN, "f2_coin2");
        for (int i = 11; i <= 20; i++) expect_bit(t + i, B_P2_COIN, 1'b0, "f2_single_pulse");
        tick(12);
        key(1'b0, 9'h006);
        expect_bit(cyc + 2, B_P2_START, 1'b0, "f2_release");
        tick(15);

        // Reset in the middle of a coin pulse.
        key(1'b1, 9'h02C);
        joystick_1 = 16'h0001;
        tick(3);
        t = cyc;
        joystick_0 = 16'h0080;
        for (int i = 1; i <= 3; i++) expect_bit(t + i, B_P1_COIN, 1'b1, "coin1_before_reset");
        expect_bits(t + 3, 15'h4400, 15'h4400, "held_before_reset");
        expect_bits(t + 4, '1, '0, "reset_mid_pulse");
        expect_bits(t + 6, '1, 15'h0400, "after_reset_release");
        tick(1);
        joystick_0 = '0;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        joystick_1 = '0;
        tick(2);
        t = cyc;
        joystick_0 = 16'h0080;
        expect_pulse(t + 1, B_P1_COIN, "coin1_after_reset");
        tick(1);
        joystick_0 = '0;
        tick(12);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_sys);
        tick(1);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
